// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the lane-FIFO round-robin drain: FSM encodings, lane count, default width.
package fifo_rr_arbiter_pkg;

  localparam int NLANE      = 4;
  localparam int DW_DEFAULT = 6;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  // Lane index reached by stepping 'step' places past 'ptr'; a step of 4 wraps back onto ptr.
  function automatic logic [1:0] lane_after(input logic [1:0] ptr, input logic [2:0] step);
    return ptr + step[1:0];
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_arbiter4.sv
// Combinational rotate-priority encoder: the first requesting lane after ptr wins, ptr itself last.
module rr_arbiter4
  import fifo_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       any
);

  always_comb begin
    gnt_idx = ptr;
    any     = 1'b0;
    for (int i = 1; i <= NLANE; i++) begin
      if (!any && req[lane_after(ptr, 3'(i))]) begin
        any     = 1'b1;
        gnt_idx = lane_after(ptr, 3'(i));
      end
    end
    gnt = any ? (4'b0001 << gnt_idx) : 4'b0000;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains four show-ahead lane FIFOs round-robin into FIFO4, one word per cycle, under a small
// RESET/INIT/IDLE/ACTIVE sequencer.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int AFTH = 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          empty0,
  input  logic          empty1,
  input  logic          empty2,
  input  logic          empty3,
  input  logic [DW-1:0] data_in0,
  input  logic [DW-1:0] data_in1,
  input  logic [DW-1:0] data_in2,
  input  logic [DW-1:0] data_in3,
  input  logic          almost_full4,
  output logic          pop0,
  output logic          pop1,
  output logic          pop2,
  output logic          pop3,
  output logic          push4,
  output logic [DW-1:0] data_out4,
  output logic          IDLE,
  output logic          active
);

  // The push pipeline is exactly one stage deep, so only one word can be in flight.
  if (AFTH != 1) begin : g_afth_check
    $error("fifo_rr_arbiter supports exactly one word in flight (AFTH=1)");
  end

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [1:0]    ptr;
  logic [3:0]    req;
  logic [3:0]    gnt;
  logic [1:0]    gnt_idx;
  logic          any;
  logic          pop_en;
  logic          do_pop;
  logic [DW-1:0] sel_data;

  assign req    = ~{empty3, empty2, empty1, empty0};
  assign pop_en = (state == ST_ACTIVE) && !almost_full4;
  assign do_pop = pop_en && any;

  rr_arbiter4 u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign {pop3, pop2, pop1, pop0} = pop_en ? gnt : 4'b0000;

  assign IDLE   = (state == ST_IDLE);
  assign active = (state == ST_ACTIVE);

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = ST_INIT;
      ST_INIT:   state_next = ST_IDLE;
      ST_IDLE:   if (|req) state_next = ST_ACTIVE;
      ST_ACTIVE: if (!(|req) && !do_pop) state_next = ST_IDLE;
      default:   state_next = ST_RESET;
    endcase
  end

  always_comb begin
    sel_data = data_in0;
    case (gnt_idx)
      2'd0:    sel_data = data_in0;
      2'd1:    sel_data = data_in1;
      2'd2:    sel_data = data_in2;
      default: sel_data = data_in3;
    endcase
  end

  // ptr starts at 3 so the first search after reset begins at lane 0.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= ST_RESET;
      ptr   <= 2'd3;
    end else begin
      state <= state_next;
      if (do_pop) ptr <= gnt_idx;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      push4     <= 1'b0;
      data_out4 <= '0;
    end else begin
      push4 <= do_pop;
      if (do_pop) data_out4 <= sel_data;
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: show-ahead lane FIFO models feed the DUT and every step is
// checked against hand-computed pop/push/state values.
module tb_fifo_rr_arbiter;

  localparam int DW = 6;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          almost_full4 = 1'b0;
  logic          empty0, empty1, empty2, empty3;
  logic [DW-1:0] data_in0, data_in1, data_in2, data_in3;
  logic          pop0, pop1, pop2, pop3;
  logic          push4;
  logic [DW-1:0] data_out4;
  logic          IDLE, active;

  logic [DW-1:0] mem [4][16];
  logic [3:0]    rdp [4] = '{default: 4'd0};
  logic [3:0]    wrp [4] = '{default: 4'd0};
  int            pop_cnt [4] = '{default: 0};
  logic [3:0]    popv;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  fifo_rr_arbiter #(.DW(DW), .AFTH(1)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .empty0       (empty0),
    .empty1       (empty1),
    .empty2       (empty2),
    .empty3       (empty3),
    .data_in0     (data_in0),
    .data_in1     (data_in1),
    .data_in2     (data_in2),
    .data_in3     (data_in3),
    .almost_full4 (almost_full4),
    .pop0         (pop0),
    .pop1         (pop1),
    .pop2         (pop2),
    .pop3         (pop3),
    .push4        (push4),
    .data_out4    (data_out4),
    .IDLE         (IDLE),
    .active       (active)
  );

  assign popv     = {pop3, pop2, pop1, pop0};
  assign empty0   = (rdp[0] == wrp[0]);
  assign empty1   = (rdp[1] == wrp[1]);
  assign empty2   = (rdp[2] == wrp[2]);
  assign empty3   = (rdp[3] == wrp[3]);
  assign data_in0 = mem[0][rdp[0]];
  assign data_in1 = mem[1][rdp[1]];
  assign data_in2 = mem[2][rdp[2]];
  assign data_in3 = mem[3][rdp[3]];

  // Lane FIFO models advance on a pop, and the pop counters stand in for the word counters.
  always @(posedge CLK) begin
    for (int n = 0; n < 4; n++) begin
      if (popv[n]) begin
        rdp[n]     <= rdp[n] + 4'd1;
        pop_cnt[n] <= pop_cnt[n] + 1;
      end
    end
  end

  task automatic applyStimulus(input int lane, input int words, input int base);
    for (int k = 0; k < words; k++) begin
      mem[lane][wrp[lane] + 4'(k)] = DW'(base + k);
    end
    wrp[lane] = wrp[lane] + 4'(words);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic checkStep(input string tag, input logic [3:0] exp_pop,
                           input logic exp_push, input logic [DW-1:0] exp_data);
    checkOutput({tag, " pop"}, 32'(popv), 32'(exp_pop));
    checkOutput({tag, " push4"}, 32'(push4), 32'(exp_push));
    if (exp_push) checkOutput({tag, " data_out4"}, 32'(data_out4), 32'(exp_data));
  endtask

  logic [3:0]    rr_pop  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [DW-1:0] rr_data [8] = '{6'd0, 6'd8, 6'd16, 6'd24, 6'd1, 6'd9, 6'd17, 6'd25};

  initial begin
    // Power-up reset, then RESET -> INIT -> IDLE.
    tick();
    tick();
    checkOutput("reset push4", 32'(push4), 0);
    checkOutput("reset data_out4", 32'(data_out4), 0);
    checkOutput("reset pops", 32'(popv), 0);
    checkOutput("reset IDLE", 32'(IDLE), 0);
    checkOutput("reset active", 32'(active), 0);
    reset = 1'b0;
    tick();
    checkOutput("init IDLE", 32'(IDLE), 0);
    checkOutput("init active", 32'(active), 0);
    tick();
    checkOutput("idle IDLE", 32'(IDLE), 1);
    checkOutput("idle active", 32'(active), 0);

    // Round robin over four lanes of two words each.
    for (int n = 0; n < 4; n++) applyStimulus(n, 2, n * 8);
    #1;
    checkOutput("rr pops while idle", 32'(popv), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      checkOutput("rr active", 32'(active), 1);
      checkStep("rr", rr_pop[i], i > 0, (i > 0) ? rr_data[i - 1] : 6'd0);
      tick();
    end
    checkStep("rr tail", 4'b0000, 1'b1, 6'd25);
    checkOutput("rr tail active", 32'(active), 1);
    tick();
    checkOutput("rr back IDLE", 32'(IDLE), 1);
    checkOutput("rr back active", 32'(active), 0);
    checkOutput("rr push4 off", 32'(push4), 0);
    for (int n = 0; n < 4; n++) checkOutput("counter lane", 32'(pop_cnt[n]), 2);

    // Single lane runs at full throughput.
    applyStimulus(2, 5, 40);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkStep("single", 4'b0100, i > 0, DW'(40 + i - 1));
      tick();
    end
    checkStep("single tail", 4'b0000, 1'b1, 6'd44);
    tick();
    checkOutput("single IDLE", 32'(IDLE), 1);
    checkOutput("single push4 off", 32'(push4), 0);

    // Latency from IDLE: pop one cycle after the lane fills, push one cycle later.
    applyStimulus(1, 1, 13);
    #1;
    checkOutput("lat active t", 32'(active), 0);
    checkOutput("lat pops t", 32'(popv), 0);
    tick();
    checkOutput("lat active t+1", 32'(active), 1);
    checkStep("lat t+1", 4'b0010, 1'b0, 6'd0);
    tick();
    checkStep("lat t+2", 4'b0000, 1'b1, 6'd13);
    tick();
    checkOutput("lat IDLE", 32'(IDLE), 1);

    // Backpressure: ptr is now 1, so order is 2,3,0,1 with a 3-cycle stall after lane 2.
    for (int n = 0; n < 4; n++) applyStimulus(n, 1, 50 + n);
    tick();
    checkStep("bp first", 4'b0100, 1'b0, 6'd0);
    tick();
    almost_full4 = 1'b1;
    #1;
    checkStep("bp stall1", 4'b0000, 1'b1, 6'd52);
    tick();
    checkStep("bp stall2", 4'b0000, 1'b0, 6'd0);
    checkOutput("bp hold data", 32'(data_out4), 52);
    tick();
    checkStep("bp stall3", 4'b0000, 1'b0, 6'd0);
    tick();
    almost_full4 = 1'b0;
    #1;
    checkStep("bp resume", 4'b1000, 1'b0, 6'd0);
    tick();
    checkStep("bp lane0", 4'b0001, 1'b1, 6'd53);
    tick();
    checkStep("bp lane1", 4'b0010, 1'b1, 6'd50);
    tick();
    checkStep("bp tail", 4'b0000, 1'b1, 6'd51);
    tick();
    checkOutput("bp IDLE", 32'(IDLE), 1);

    // Reset mid-burst clears outputs without a clock edge and drops the in-flight word.
    applyStimulus(0, 3, 60);
    tick();
    checkStep("mid first", 4'b0001, 1'b0, 6'd0);
    tick();
    checkStep("mid second", 4'b0001, 1'b1, 6'd60);
    reset = 1'b1;
    #1;
    checkOutput("mid reset push4", 32'(push4), 0);
    checkOutput("mid reset data_out4", 32'(data_out4), 0);
    checkOutput("mid reset pops", 32'(popv), 0);
    checkOutput("mid reset active", 32'(active), 0);
    checkOutput("mid reset IDLE", 32'(IDLE), 0);
    for (int n = 0; n < 4; n++) wrp[n] = rdp[n];
    tick();
    checkOutput("mid held push4", 32'(push4), 0);
    reset = 1'b0;
    tick();
    checkOutput("mid init IDLE", 32'(IDLE), 0);
    checkOutput("mid init active", 32'(active), 0);
    tick();
    checkOutput("mid idle IDLE", 32'(IDLE), 1);

    // After reset ptr is 3 again, so lane 0 beats lane 3.
    applyStimulus(0, 1, 20);
    applyStimulus(3, 1, 33);
    tick();
    checkStep("post lane0", 4'b0001, 1'b0, 6'd0);
    tick();
    checkStep("post lane3", 4'b1000, 1'b1, 6'd20);
    tick();
    checkStep("post tail", 4'b0000, 1'b1, 6'd33);
    tick();
    checkOutput("post IDLE", 32'(IDLE), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
